// File: rtl/ram_pkg.sv
// Shared types and limits for the 1R1W pipelined RAM.
package ram_pkg;

   // Read-during-write policy when a read and a write hit the same word on one edge.
   typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;

   // Deepest supported read pipeline (request edge to rd_valid_o).
   localparam int unsigned MaxReadLatency = 3;

endpackage

// File: rtl/ram_rd_pipe.sv
// Valid+data delay line. Data registers load only when a valid entry
// arrives, so the last stage holds its value between reads.
module ram_rd_pipe #(
   parameter int unsigned Width  = 8,
   parameter int unsigned Stages = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             vld_i,
   input  logic [Width-1:0] data_i,
   output logic             vld_o,
   output logic [Width-1:0] data_o
);

   if (Stages == 0) begin : g_thru
      // No extra registers: clock and reset are intentionally unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign vld_o  = vld_i;
      assign data_o = data_i;
   end else begin : g_pipe
      logic [Stages:0]            vld_pipe;
      logic [Stages:0][Width-1:0] data_pipe;
      logic [Stages:1]            vld_d, vld_q;
      logic [Stages:1][Width-1:0] data_d, data_q;

      // Shift valid every cycle; advance data only behind a valid bit.
      always_comb begin
         vld_pipe  = {vld_q, vld_i};
         data_pipe = {data_q, data_i};
         vld_d     = '0;
         data_d    = data_q;
         for (int i = 1; i <= int'(Stages); i++) begin
            vld_d[i] = vld_pipe[i-1];
            if (vld_pipe[i-1]) data_d[i] = data_pipe[i-1];
         end
      end

      // Pipeline registers; reset drops anything in flight.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld_q  <= '0;
            data_q <= '0;
         end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
         end
      end

      assign vld_o  = vld_q[Stages];
      assign data_o = data_q[Stages];
   end

endmodule

// File: rtl/ram_1r1w_pipe.sv
// Single-read single-write RAM with lane write enables, 1..3 cycle read
// latency, selectable read-during-write policy and held read data.
module ram_1r1w_pipe
   import ram_pkg::*;
#(
   parameter int unsigned Width       = 8,
   parameter int unsigned LaneWidth   = 8,
   parameter int unsigned Depth       = 512,
   parameter int unsigned ReadLatency = 1,
   parameter rdw_mode_e   RdwMode     = RDW_OLD,
   localparam int unsigned AddrWidth  = $clog2(Depth),
   localparam int unsigned Lanes      = Width / LaneWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_valid_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [Width-1:0]     wr_data_i,
   input  logic [Lanes-1:0]     wr_lane_i,
   input  logic                 rd_valid_i,
   input  logic [AddrWidth-1:0] rd_addr_i,
   output logic [Width-1:0]     rd_data_o,
   output logic                 rd_valid_o
);

   if (Width % LaneWidth != 0) begin : g_bad_width
      $error("ram_1r1w_pipe: Width must be a multiple of LaneWidth");
   end
   if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
      $error("ram_1r1w_pipe: ReadLatency must be 1, 2 or 3");
   end
   if (Depth < 2) begin : g_bad_depth
      $error("ram_1r1w_pipe: Depth must be at least 2");
   end

   // Extra bit so Depth itself is representable for power-of-two depths.
   localparam logic [AddrWidth:0] DepthLim = (AddrWidth + 1)'(Depth);

   logic [Width-1:0] mem [Depth];

`ifndef SYNTHESIS
   initial begin
      for (int i = 0; i < int'(Depth); i++) mem[i] = '0;
   end
`endif

   logic             wr_en, rd_en, rd_in_rng, rdw_hit;
   logic [Width-1:0] wr_mask, rd_word;
   logic             s1_vld_d, s1_vld_q;
   logic [Width-1:0] s1_data_d, s1_data_q;

   // Request qualification; nothing is accepted while reset is high.
   always_comb begin
      wr_en     = wr_valid_i && !rst_i && ({1'b0, wr_addr_i} < DepthLim);
      rd_en     = rd_valid_i && !rst_i;
      rd_in_rng = {1'b0, rd_addr_i} < DepthLim;
   end

   // Array write: only enabled lanes change.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int k = 0; k < int'(Lanes); k++) begin
            if (wr_lane_i[k]) mem[wr_addr_i][k*LaneWidth +: LaneWidth] <= wr_data_i[k*LaneWidth +: LaneWidth];
         end
      end
   end

   // Stage 1 input: array word (0 when out of range) with optional same-edge bypass.
   always_comb begin
      wr_mask = '0;
      for (int k = 0; k < int'(Lanes); k++) wr_mask[k*LaneWidth +: LaneWidth] = {LaneWidth{wr_lane_i[k]}};
      rd_word   = rd_in_rng ? mem[rd_addr_i] : '0;
      rdw_hit   = (RdwMode == RDW_NEW) && wr_en && rd_en && (wr_addr_i == rd_addr_i);
      s1_vld_d  = rd_en;
      s1_data_d = s1_data_q;
      if (rd_en) s1_data_d = rdw_hit ? ((rd_word & ~wr_mask) | (wr_data_i & wr_mask)) : rd_word;
   end

   // Stage 1 capture; data holds when no read is issued.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
      end
   end

   ram_rd_pipe #(
      .Width  (Width),
      .Stages (ReadLatency - 1)
   ) u_rd_pipe (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .vld_i  (s1_vld_q),
      .data_i (s1_data_q),
      .vld_o  (rd_valid_o),
      .data_o (rd_data_o)
   );

endmodule

// File: tb/tb_ram_1r1w_pipe.sv
// Bench: three RAM configurations share one stimulus stream; a model array
// and per-instance scoreboards predict data and arrival cycle of each read.
module tb_ram_1r1w_pipe;
   import ram_pkg::*;

   localparam int NI = 3;
   localparam int RL     [NI] = '{3, 1, 2};
   localparam bit IS_NEW [NI] = '{1'b1, 1'b0, 1'b1};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_valid = 1'b0, rd_valid = 1'b0;
   logic [8:0]  wr_addr = '0, rd_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_lane = '0;
   logic [31:0] rd_data [NI];
   logic        rd_vld  [NI];

   always #5 clk = ~clk;

   ram_1r1w_pipe #(.Width(32), .LaneWidth(8), .Depth(300), .ReadLatency(3), .RdwMode(RDW_NEW)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_lane_i(wr_lane), .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]), .rd_valid_o(rd_vld[0]));
   ram_1r1w_pipe #(.Width(32), .LaneWidth(8), .Depth(300), .ReadLatency(1), .RdwMode(RDW_OLD)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_lane_i(wr_lane), .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]), .rd_valid_o(rd_vld[1]));
   ram_1r1w_pipe #(.Width(32), .LaneWidth(8), .Depth(300), .ReadLatency(2), .RdwMode(RDW_NEW)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_lane_i(wr_lane), .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_data_o(rd_data[2]), .rd_valid_o(rd_vld[2]));

   int          n_chk = 0, n_err = 0;
   int          edge_cnt = 0;
   logic [31:0] mdl [512];
   logic [31:0] exp_q [NI][$];
   int          cyc_q [NI][$];
   logic [31:0] last [NI];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Output monitor: pop on each pulse, otherwise the data must hold.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            last[i] = '0;
         end else if (rd_vld[i]) begin
            if (exp_q[i].size() == 0) begin
               chk($sformatf("spurious_vld[%0d]", i), 64'd1, 64'd0);
            end else begin
               chk($sformatf("rd_cycle[%0d]", i), 64'(edge_cnt), 64'(cyc_q[i].pop_front()));
               last[i] = exp_q[i].pop_front();
               chk($sformatf("rd_data[%0d]", i), 64'(rd_data[i]), 64'(last[i]));
            end
         end else begin
            chk($sformatf("hold[%0d]", i), 64'(rd_data[i]), 64'(last[i]));
         end
      end
   end

   // One cycle of stimulus; expectations are pushed at issue time.
   task automatic step(input logic wv, input logic [8:0] wa, input logic [31:0] wd,
                       input logic [3:0] wl, input logic rv, input logic [8:0] ra);
      logic [31:0] old, m, merged;
      if (rv) begin
         old = (ra < 9'd300) ? mdl[ra] : 32'h0;
         for (int k = 0; k < 4; k++) m[k*8 +: 8] = {8{wl[k]}};
         merged = (wv && wa == ra && wa < 9'd300) ? ((old & ~m) | (wd & m)) : old;
         for (int i = 0; i < NI; i++) begin
            exp_q[i].push_back(IS_NEW[i] ? merged : old);
            cyc_q[i].push_back(edge_cnt + RL[i]);
         end
      end
      if (wv && wa < 9'd300)
         for (int k = 0; k < 4; k++) if (wl[k]) mdl[wa][k*8 +: 8] = wd[k*8 +: 8];
      wr_valid = wv; wr_addr = wa; wr_data = wd; wr_lane = wl;
      rd_valid = rv; rd_addr = ra;
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_valid = 1'b0; wr_lane = '0;
   endtask

   task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] l);
      step(1'b1, a, d, l, 1'b0, '0);
   endtask

   task automatic rd(input logic [8:0] a);
      step(1'b0, '0, '0, '0, 1'b1, a);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mdl[i] = '0;
      for (int i = 0; i < NI; i++) last[i] = '0;

      // Reset state
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_vld[%0d]", i), 64'(rd_vld[i]), 64'd0);
         chk($sformatf("rst_data[%0d]", i), 64'(rd_data[i]), 64'd0);
      end
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      idle(2);

      // Async reset mid-cycle with a read of addr 5 in flight
      wr(9'd5, 32'hDEADBEEF, 4'hF);
      rd(9'd5);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("midrst_vld[%0d]", i), 64'(rd_vld[i]), 64'd0);
         chk($sformatf("midrst_data[%0d]", i), 64'(rd_data[i]), 64'd0);
         exp_q[i].delete();
         cyc_q[i].delete();
         last[i] = '0;
      end
      @(posedge clk); #1 rst = 1'b0;
      idle(6);
      rd(9'd5);                          // array survives reset

      // Lane writes
      wr(9'd3, 32'hAABBCCDD, 4'b1111);
      wr(9'd3, 32'h11223344, 4'b0101);
      rd(9'd3);
      wr(9'd3, 32'hFFFFFFFF, 4'b0000);   // no lanes: no-op
      rd(9'd3);
      idle(4);

      // Back-to-back reads
      for (int i = 0; i < 8; i++) wr(9'(i), 32'h10 + 32'(i), 4'hF);
      for (int i = 0; i < 8; i++) rd(9'(i));
      idle(4);

      // Same-edge collisions, full and partial lanes
      wr(9'd9, 32'h55, 4'hF);
      step(1'b1, 9'd9, 32'hA3, 4'hF, 1'b1, 9'd9);
      wr(9'd9, 32'h55AA, 4'hF);
      step(1'b1, 9'd9, 32'h0, 4'b0001, 1'b1, 9'd9);
      // Different-address collision, then write behind an in-flight read
      step(1'b1, 9'd10, 32'h77, 4'hF, 1'b1, 9'd9);
      rd(9'd10);
      wr(9'd10, 32'h88, 4'hF);
      idle(4);

      // Bounds and hold
      wr(9'd299, 32'hCAFEF00D, 4'hF);
      wr(9'd300, 32'h12345678, 4'hF);    // ignored
      rd(9'd299);
      rd(9'd300);
      rd(9'd511);
      idle(10);
      rd(9'd299);
      idle(10);

      // Random mix
      for (int n = 0; n < 60; n++) begin
         logic [8:0] wa, ra;
         wa = $urandom_range(0, 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(295, 305));
         ra = $urandom_range(0, 2) == 0 ? wa :
              ($urandom_range(0, 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(295, 305)));
         step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ra);
      end
      idle(6);

      for (int i = 0; i < NI; i++) chk($sformatf("drain[%0d]", i), 64'(exp_q[i].size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
